// File: rtl/fighter_ctrl.sv
// rtl/fighter_ctrl.sv - fighter sprite controller: movement, animation, HP and sprite fetch
module fighter_ctrl #(
  parameter int          SCALE_SHIFT     = 1,
  parameter int          HP_MAX          = 20,
  parameter int          X_START         = 520,
  parameter int          Y_POS           = 300,
  parameter int          X_MIN           = 10,
  parameter int          X_MAX           = 560,
  parameter int          STEP            = 3,
  parameter int          KNOCK           = 3,
  parameter int          LUNGE           = 4,
  parameter bit          FACE_LEFT       = 1'b1,
  parameter int          SEP             = 50,
  parameter int          TICKS_PER_FRAME = 4,
  // per-state tables, state 0 in the least significant slot
  parameter logic [55:0]  NFRAMES = {8'd3, 8'd2, 8'd1, 8'd4, 8'd6, 8'd6, 8'd4},
  parameter logic [69:0]  RW      = {7{10'd40}},
  parameter logic [69:0]  RH      = {7{10'd50}},
  parameter logic [132:0] BASE    = {19'd46000, 19'd42000, 19'd40000, 19'd32000,
                                     19'd20000, 19'd8000, 19'd0},
  parameter logic [7:0]   TRANSP  = 8'h00
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        start,
  input  logic        enable,
  input  logic        move_l,
  input  logic        move_r,
  input  logic        attack_req,
  input  logic        defend,
  input  logic        hit,
  input  logic [18:0] opp_x,
  input  logic        opp_block,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [7:0]  rom_data,
  output logic [18:0] rom_addr,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic [18:0] pos_x,
  output logic [18:0] hp,
  output logic [2:0]  state,
  output logic [7:0]  anim_frame,
  output logic        dead,
  output logic        strike
);

  typedef enum logic [2:0] {
    ST_STAND  = 3'd0,
    ST_WALK_L = 3'd1,
    ST_WALK_R = 3'd2,
    ST_ATTACK = 3'd3,
    ST_DEFEND = 3'd4,
    ST_HURT   = 3'd5,
    ST_DIE    = 3'd6
  } state_t;

  // signed per-tick displacements; "toward" means toward the facing direction
  localparam logic signed [20:0] STEP_D  = 21'(STEP);
  localparam logic signed [20:0] KNOCK_D = FACE_LEFT ? 21'(KNOCK) : -21'(KNOCK);
  localparam logic signed [20:0] LUNGE_D = FACE_LEFT ? -21'(LUNGE) : 21'(LUNGE);
  localparam logic signed [20:0] DIE_D   = FACE_LEFT ? 21'sd4 : -21'sd4;
  localparam logic signed [20:0] XMIN_S  = 21'(X_MIN);
  localparam logic signed [20:0] XMAX_S  = 21'(X_MAX);
  localparam logic signed [20:0] SEP_S   = 21'(SEP);
  localparam logic [7:0]         DIV_TOP = 8'(TICKS_PER_FRAME - 1);
  localparam logic [7:0]         NF_ATK  = NFRAMES[31:24];

  state_t      state_q, state_d;
  logic [7:0]  frame_d;
  logic [7:0]  div_q, div_d;
  logic [18:0] x_d, hp_d;
  logic [9:0]  y_q, y_d;
  logic        pend_q, pend_d;

  logic        fc_s1, fc_s2, fc_s3;
  logic        start_d, hit_d;
  logic        tick, start_rise, hit_rise;

  logic [7:0]  nf_cur;
  logic [9:0]  rw_cur, rh_cur;
  logic [18:0] base_cur;

  logic              frame_wrap, last_frame;
  logic signed [20:0] dx, nx, opp_s;
  logic [9:0]        dy;

  logic [18:0] px_off, py_off, box_w, box_h;
  logic        in_box, in_box_d1, en_d1;

  assign tick       = fc_s2 & ~fc_s3;
  assign start_rise = start & ~start_d;
  assign hit_rise   = hit & ~hit_d;

  // synchronise frame_clk and keep previous levels for edge detection
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_s1   <= 1'b0;
      fc_s2   <= 1'b0;
      fc_s3   <= 1'b0;
      start_d <= 1'b0;
      hit_d   <= 1'b0;
    end else begin
      fc_s1   <= frame_clk;
      fc_s2   <= fc_s1;
      fc_s3   <= fc_s2;
      start_d <= start;
      hit_d   <= hit;
    end
  end

  // per-state table lookups for the current state
  always_comb begin
    nf_cur   = NFRAMES[8*state_q +: 8];
    rw_cur   = RW[10*state_q +: 10];
    rh_cur   = RH[10*state_q +: 10];
    base_cur = BASE[19*state_q +: 19];
  end

  // next-state, animation, HP and movement; everything but pending waits for a tick
  always_comb begin
    state_d    = state_q;
    frame_d    = anim_frame;
    div_d      = div_q;
    x_d        = pos_x;
    y_d        = y_q;
    hp_d       = hp;
    pend_d     = pend_q;
    dx         = '0;
    dy         = '0;
    nx         = '0;
    opp_s      = $signed({2'b00, opp_x});
    frame_wrap = (div_q == DIV_TOP);
    last_frame = (anim_frame == 8'(nf_cur - 8'd1));

    if (!enable) begin
      state_d = ST_STAND;
      frame_d = '0;
      div_d   = '0;
      pend_d  = 1'b0;
    end else begin
      // a hit edge on the tick cycle itself is kept for the following tick
      pend_d = tick ? hit_rise : (pend_q | hit_rise);

      if (tick) begin
        if (pend_q && state_q != ST_DEFEND && hp != '0)
          hp_d = hp - 19'd1;

        if (hp == '0)
          state_d = ST_DIE;
        else if (state_q == ST_ATTACK || state_q == ST_HURT)
          state_d = (frame_wrap && last_frame) ? ST_STAND : state_q;
        else if (pend_q && state_q != ST_DEFEND)
          state_d = ST_HURT;
        else if (attack_req && (state_q == ST_STAND || state_q == ST_WALK_L ||
                                state_q == ST_WALK_R))
          state_d = ST_ATTACK;
        else if (defend)
          state_d = ST_DEFEND;
        else if (move_l ^ move_r)
          state_d = move_l ? ST_WALK_L : ST_WALK_R;
        else
          state_d = ST_STAND;

        if (state_d != state_q) begin
          frame_d = '0;
          div_d   = '0;
        end else if (frame_wrap) begin
          div_d = '0;
          if (!last_frame)
            frame_d = anim_frame + 8'd1;
          else if (state_q != ST_DIE)
            frame_d = '0;
        end else begin
          div_d = div_q + 8'd1;
        end

        // movement follows the state being entered on this tick
        case (state_d)
          ST_WALK_L: dx = -STEP_D;
          ST_WALK_R: dx = STEP_D;
          ST_HURT:   dx = KNOCK_D;
          ST_ATTACK: if (frame_d == '0) dx = LUNGE_D;
          ST_DIE:    if (frame_d == '0) begin dx = DIE_D; dy = 10'd4; end
          default:   dx = '0;
        endcase

        nx = $signed({2'b00, pos_x}) + dx;
        // stay on our own side of a solid opponent
        if (opp_block) begin
          if (pos_x >= opp_x) begin
            if (nx < opp_s + SEP_S) nx = opp_s + SEP_S;
          end else begin
            if (nx > opp_s - SEP_S) nx = opp_s - SEP_S;
          end
        end
        if (nx < XMIN_S) nx = XMIN_S;
        if (nx > XMAX_S) nx = XMAX_S;
        x_d = 19'(nx);
        y_d = (y_q >= dy) ? (y_q - dy) : '0;
      end
    end
  end

  // state and fighter registers; start edge respawns exactly like Reset
  always_ff @(posedge Clk) begin
    if (Reset || start_rise) begin
      state_q    <= ST_STAND;
      anim_frame <= '0;
      div_q      <= '0;
      pos_x      <= 19'(X_START);
      y_q        <= 10'(Y_POS);
      hp         <= 19'(HP_MAX);
      pend_q     <= 1'b0;
      in_box_d1  <= 1'b0;
      en_d1      <= 1'b0;
    end else begin
      state_q    <= state_d;
      anim_frame <= frame_d;
      div_q      <= div_d;
      pos_x      <= x_d;
      y_q        <= y_d;
      hp         <= hp_d;
      pend_q     <= pend_d;
      in_box_d1  <= in_box;
      en_d1      <= enable;
    end
  end

  // sprite box test and ROM address for the current pixel
  always_comb begin
    box_w    = 19'(rw_cur) << SCALE_SHIFT;
    box_h    = 19'(rh_cur) << SCALE_SHIFT;
    px_off   = 19'(DrawX) - pos_x;
    py_off   = 19'(DrawY) - 19'(y_q);
    in_box   = (19'(DrawX) >= pos_x) && (px_off < box_w) &&
               (DrawY >= y_q) && (py_off < box_h);
    rom_addr = base_cur
             + 19'(anim_frame) * 19'(rw_cur) * 19'(rh_cur)
             + (py_off >> SCALE_SHIFT) * 19'(rw_cur)
             + (px_off >> SCALE_SHIFT);
  end

  assign pix_valid = in_box_d1 && en_d1 && (rom_data != TRANSP);
  assign pix_data  = rom_data;
  assign state     = state_q;
  assign dead      = (hp == '0);
  assign strike    = (state_q == ST_ATTACK) && (anim_frame == (NF_ATK >> 1));

endmodule

// File: tb/tb_fighter_ctrl.sv
// tb/tb_fighter_ctrl.sv - directed self-checking bench for fighter_ctrl
module tb_fighter_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, frame_clk, start, enable;
  logic        move_l, move_r, attack_req, defend, hit;
  logic [18:0] opp_x;
  logic        opp_block;
  logic [9:0]  DrawX, DrawY;
  logic [7:0]  rom_data = 8'h00;
  logic [18:0] rom_addr;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic [18:0] pos_x, hp;
  logic [2:0]  state;
  logic [7:0]  anim_frame;
  logic        dead, strike;

  int checks = 0;
  int errors = 0;

  fighter_ctrl #(
    .SCALE_SHIFT(1), .HP_MAX(20), .X_START(520), .Y_POS(300),
    .X_MIN(10), .X_MAX(560), .STEP(3), .KNOCK(3), .LUNGE(4),
    .FACE_LEFT(1'b1), .SEP(50), .TICKS_PER_FRAME(4),
    .NFRAMES({8'd3, 8'd2, 8'd1, 8'd4, 8'd6, 8'd6, 8'd4}),
    .RW({7{10'd40}}), .RH({7{10'd50}}),
    .BASE({19'd46000, 19'd42000, 19'd40000, 19'd32000, 19'd20000, 19'd8000, 19'd0}),
    .TRANSP(8'h00)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start(start), .enable(enable),
    .move_l(move_l), .move_r(move_r), .attack_req(attack_req), .defend(defend),
    .hit(hit), .opp_x(opp_x), .opp_block(opp_block), .DrawX(DrawX), .DrawY(DrawY),
    .rom_data(rom_data), .rom_addr(rom_addr), .pix_valid(pix_valid), .pix_data(pix_data),
    .pos_x(pos_x), .hp(hp), .state(state), .anim_frame(anim_frame), .dead(dead),
    .strike(strike)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rom_f(input logic [18:0] a);
    return (a % 3 == 0) ? 8'h00 : a[7:0];
  endfunction

  always @(posedge Clk) rom_data <= rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_tick();
    frame_clk = 1'b1;
    cyc(4);
    frame_clk = 1'b0;
    cyc(4);
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    cyc(1);
    hit = 1'b0;
    cyc(1);
  endtask

  task automatic respawn();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(1);
  endtask

  int exp_x;
  int xs[12] = '{518, 519, 520, 521, 522, 523, 524, 525, 598, 599, 600, 601};
  logic        exp_in;
  logic [18:0] exp_a;

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; start = 1'b0; enable = 1'b0;
    move_l = 1'b0; move_r = 1'b0; attack_req = 1'b0; defend = 1'b0; hit = 1'b0;
    opp_x = 19'd0; opp_block = 1'b0; DrawX = 10'd0; DrawY = 10'd0;
    cyc(3);
    Reset = 1'b0;
    cyc(1);
    chk("reset_pos", pos_x, 520);
    chk("reset_hp", hp, 20);
    chk("reset_state", state, 0);
    chk("reset_frame", anim_frame, 0);
    chk("reset_dead", dead, 0);
    chk("reset_strike", strike, 0);
    chk("reset_pv", pix_valid, 0);

    // walk left with the opponent out of the way
    enable = 1'b1;
    move_l = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      do_tick();
      chk("walk_state", state, 1);
      chk("walk_pos", pos_x, 520 - 3 * k);
      chk("walk_frame", anim_frame, ((k - 1) / 4) % 6);
      if (k == 10) chk("walk_pos10", pos_x, 490);
    end
    move_l = 1'b0;

    respawn();
    chk("start_pos", pos_x, 520);
    chk("start_state", state, 0);

    // first hit: recoil +3 per tick for the full HURT animation
    pulse_hit();
    for (int k = 1; k <= 9; k++) begin
      do_tick();
      if (k == 1) chk("hurt_hp", hp, 19);
      chk("hurt_state", state, (k <= 8) ? 5 : 0);
      chk("hurt_pos", pos_x, 520 + 3 * ((k <= 8) ? k : 8));
    end
    for (int h = 0; h < 2; h++) begin
      pulse_hit();
      repeat (9) do_tick();
    end
    chk("hits3_hp", hp, 17);
    chk("hits3_state", state, 0);
    chk("hits3_pos", pos_x, 560);

    // blocked hit
    defend = 1'b1;
    do_tick();
    pulse_hit();
    do_tick();
    chk("def_hp", hp, 17);
    chk("def_state", state, 4);
    defend = 1'b0;
    do_tick();
    chk("def_release", state, 0);

    // hits to death
    for (int h = 1; h <= 20; h++) begin
      pulse_hit();
      do_tick();
      if (h == 17) chk("hp_zero", hp, 0);
    end
    chk("die_hp", hp, 0);
    chk("die_dead", dead, 1);
    chk("die_state", state, 6);
    pulse_hit();
    do_tick();
    chk("die_hp_sat", hp, 0);
    repeat (16) do_tick();
    chk("die_hold_frame", anim_frame, 2);
    chk("die_hold_state", state, 6);
    respawn();
    chk("revive_hp", hp, 20);
    chk("revive_pos", pos_x, 520);
    chk("revive_dead", dead, 0);
    chk("revive_state", state, 0);

    // attack: lunge on frame 0, strike on frame 2
    attack_req = 1'b1;
    do_tick();
    attack_req = 1'b0;
    chk("atk_state", state, 3);
    chk("atk_pos1", pos_x, 516);
    chk("atk_strike0", strike, 0);
    repeat (3) do_tick();
    chk("atk_pos4", pos_x, 504);
    repeat (5) do_tick();
    chk("atk_frame9", anim_frame, 2);
    chk("atk_strike9", strike, 1);
    chk("atk_pos9", pos_x, 504);
    repeat (4) do_tick();
    chk("atk_strike13", strike, 0);
    repeat (4) do_tick();
    chk("atk_done", state, 0);

    // solid opponent separation, then right wall
    respawn();
    opp_x = 19'd500;
    opp_block = 1'b1;
    move_l = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      do_tick();
      chk("sep_pos", pos_x, 550);
    end
    move_l = 1'b0;
    move_r = 1'b1;
    exp_x = 550;
    for (int k = 1; k <= 5; k++) begin
      do_tick();
      exp_x = (exp_x + 3 > 560) ? 560 : exp_x + 3;
      chk("wall_pos", pos_x, exp_x);
    end
    move_r = 1'b0;
    opp_block = 1'b0;

    // disabled fighter ignores controls
    enable = 1'b0;
    move_l = 1'b1;
    do_tick();
    chk("dis_state", state, 0);
    chk("dis_pos", pos_x, 560);
    move_l = 1'b0;
    enable = 1'b1;

    // pixel sweep across row 6 of the standing sprite at (520,300)
    respawn();
    DrawY = 10'd306;
    for (int i = 0; i < 12; i++) begin
      DrawX = 10'(xs[i]);
      #1;
      exp_in = (xs[i] >= 520) && (xs[i] < 600);
      exp_a  = 19'(120 + (xs[i] - 520) / 2);
      if (exp_in) chk("sweep_addr", rom_addr, exp_a);
      @(negedge Clk);
      chk("sweep_pv", pix_valid, exp_in && (rom_f(exp_a) != 8'h00));
      if (exp_in) chk("sweep_data", pix_data, rom_f(exp_a));
    end

    enable = 1'b0;
    DrawX = 10'd522;
    cyc(2);
    chk("dis_pv", pix_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
